link_resp_tx: RTL and testbench

Responder-side byte transmitter for the req/ack link: the return direction, sending bytes from the slave end back to the master end.
- Local logic pushes bytes into a small FIFO.
- The block drains the FIFO over a 4-phase req/ack handshake with 8-bit data.
- It counts completed transfers and pulses done at the end of each burst.
- It sits beside the existing slave FSM in the link top and drives a second req/ack/data channel.

---
 rtl/link_resp_tx_pkg.sv | 13 +
 rtl/link_byte_fifo.sv | 64 ++++++
 rtl/link_resp_tx.sv | 101 ++++++++++
 tb/tb_link_resp_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_resp_tx_pkg.sv
// Shared definitions for the req/ack link responder transmitter.
// Holds the link data width and the transmit FSM state encoding so the
// top and any neighbouring link logic agree on the same values.
package link_resp_tx_pkg;

  localparam int LINK_DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ_HI = 2'd1;
  localparam logic [1:0] ST_REQ_LO = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/link_byte_fifo.sv
// Small synchronous byte FIFO feeding the responder transmitter.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset (clears pointers and occupancy)
//   push       write request; ignored when full
//   push_data  byte to write
//   pop        remove head entry; ignored when empty
//   head       current head entry (valid when not empty)
//   count      registered occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module link_byte_fifo
  import link_resp_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [LINK_DATA_W-1:0]   push_data,
  input  logic                     pop,
  output logic [LINK_DATA_W-1:0]   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [LINK_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/link_resp_tx.sv
// Responder-side byte transmitter for the req/ack link. Local logic queues
// bytes into a small FIFO; the FSM drains them toward the master end over a
// 4-phase req/ack handshake, counts completed handshakes and pulses done
// when a burst of BURST_LEN transfers completes.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   push_valid  local byte offered for queuing
//   push_data   byte to queue
//   push_ready  FIFO can accept a byte this cycle
//   ack         acknowledge from the master end
//   req         request, high while data is valid
//   data        byte being transferred
//   busy        FSM not idle or FIFO not empty
//   sent_count  handshakes completed in the current burst
//   done        one-cycle pulse when a burst completes
module link_resp_tx
  import link_resp_tx_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [LINK_DATA_W-1:0] push_data,
  output logic                   push_ready,
  input  logic                   ack,
  output logic                   req,
  output logic [LINK_DATA_W-1:0] data,
  output logic                   busy,
  output logic [7:0]             sent_count,
  output logic                   done
);

  logic [1:0]               state;
  logic [LINK_DATA_W-1:0]   head;
  logic [$clog2(DEPTH):0]   occ;
  logic                     full;
  logic                     empty;
  logic                     pop;
  logic [7:0]               next_count;

  link_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (occ),
    .full      (full),
    .empty     (empty)
  );

  // The head byte stays in the FIFO until the master has released ack,
  // so a reset mid-handshake simply discards it along with the rest.
  assign pop        = (state == ST_REQ_LO) && !ack;
  assign push_ready = !full;
  assign busy       = (state != ST_IDLE) || (occ != '0);
  assign done       = (state == ST_DONE);
  assign next_count = sent_count + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req        <= 1'b0;
      data       <= '0;
      sent_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // ack seen here is a protocol error and is deliberately ignored.
          if (!empty) begin
            data  <= head;
            req   <= 1'b1;
            state <= ST_REQ_HI;
          end
        end
        ST_REQ_HI: begin
          if (ack) begin
            req   <= 1'b0;
            state <= ST_REQ_LO;
          end
        end
        ST_REQ_LO: begin
          if (!ack) begin
            sent_count <= next_count;
            state      <= (next_count == 8'(BURST_LEN)) ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          sent_count <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_resp_tx.sv
module tb_link_resp_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       push_ready;
  logic       ack = 1'b0;
  logic       req;
  logic [7:0] data;
  logic       busy;
  logic [7:0] sent_count;
  logic       done;

  always #5 clk = ~clk;

  link_resp_tx #(.DEPTH(4), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .ack        (ack),
    .req        (req),
    .data       (data),
    .busy       (busy),
    .sent_count (sent_count),
    .done       (done)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         n_sent   = 0;
  int         done_cnt = 0;
  bit         ack_en   = 1'b0;
  int         base_sent;
  int         base_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_valid = 1'b1;
    push_data  = b;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && !req && !ack) break;
    end
    check({name, "_timeout"}, 32'(k < 300), 32'd1);
  endtask

  // Master-side responder: ack mirrors req one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack_en) ack = req;
    end
  end

  // Monitor: each rising req presents the next expected byte.
  logic       req_d  = 1'b0;
  logic       done_d = 1'b0;
  logic [7:0] cur    = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (req && !req_d) begin
          n_sent++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h, expected no transfer", data);
          end else begin
            check("byte_order", data, exp_q.pop_front());
          end
          cur = data;
        end
        if (!req && req_d) check("data_hold", data, cur);
        if (done) begin
          done_cnt++;
          check("done_sent_count", sent_count, 32'd4);
          check("done_single_cycle", done_d, 1'b0);
        end
      end
      req_d  = rst ? req : 1'b0;
      done_d = rst ? done : 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset hold with a byte offered
    rst = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'h77;
    repeat (3) tick();
    @(negedge clk);
    check("reset_req", req, 1'b0);
    check("reset_data", data, 8'h00);
    check("reset_push_ready", push_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_sent_count", sent_count, 8'd0);
    check("reset_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_valid = 1'b0;
    tick();
    @(negedge clk);
    check("after_reset_busy", busy, 1'b0);
    check("after_reset_req", req, 1'b0);

    // Single byte
    ack_en = 1'b1;
    base_sent = n_sent;
    base_done = done_cnt;
    exp_q.push_back(8'hA5);
    push_byte(8'hA5);
    @(negedge clk);
    check("single_req_not_yet", req, 1'b0);
    check("single_busy", busy, 1'b1);
    @(negedge clk);
    check("single_req_rise", req, 1'b1);
    check("single_data", data, 8'hA5);
    wait_idle("single");
    check("single_sent_count", sent_count, 8'd1);
    check("single_no_done", done_cnt - base_done, 0);
    check("single_n_sent", n_sent - base_sent, 1);

    // Burst of four
    do_reset();
    base_sent = n_sent;
    base_done = done_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    wait_idle("burst");
    check("burst_done_pulses", done_cnt - base_done, 1);
    check("burst_sent_count", sent_count, 8'd0);
    check("burst_busy", busy, 1'b0);
    check("burst_n_sent", n_sent - base_sent, 4);

    // Full FIFO: fifth byte dropped
    do_reset();
    ack_en = 1'b0;
    ack = 1'b0;
    base_sent = n_sent;
    base_done = done_cnt;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    push_valid = 1'b1;
    push_data  = 8'h05;
    @(negedge clk);
    check("full_push_ready", push_ready, 1'b0);
    check("full_req_held", req, 1'b1);
    check("full_data_held", data, 8'h01);
    tick();
    push_valid = 1'b0;
    repeat (4) tick();
    ack_en = 1'b1;
    wait_idle("full");
    check("full_n_sent", n_sent - base_sent, 4);
    check("full_done_pulses", done_cnt - base_done, 1);

    // Push offered while full on the handshake-completion cycle
    do_reset();
    ack_en = 1'b0;
    ack = 1'b0;
    base_sent = n_sent;
    base_done = done_cnt;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA4);
    exp_q.push_back(8'hA5);
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'hA5;
    @(negedge clk);
    check("simul_ready_full", push_ready, 1'b0);
    check("simul_req_low", req, 1'b0);
    tick();
    @(negedge clk);
    check("simul_ready_after_pop", push_ready, 1'b1);
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    check("simul_refull", push_ready, 1'b0);
    ack_en = 1'b1;
    wait_idle("simul");
    check("simul_n_sent", n_sent - base_sent, 5);
    check("simul_done_pulses", done_cnt - base_done, 1);
    check("simul_sent_count", sent_count, 8'd1);

    // Reset during REQ_HI with three bytes queued
    do_reset();
    ack_en = 1'b0;
    ack = 1'b0;
    exp_q.push_back(8'hC1);
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    @(negedge clk);
    check("midrst_req_before", req, 1'b1);
    base_sent = n_sent;
    base_done = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_push_ready", push_ready, 1'b1);
    check("midrst_sent_count", sent_count, 8'd0);
    check("midrst_data", data, 8'h00);
    ack_en = 1'b1;
    repeat (20) tick();
    check("midrst_no_send", n_sent - base_sent, 0);
    check("midrst_no_done", done_cnt - base_done, 0);
    check("midrst_busy_after", busy, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
